// File: rtl/riscv_pkg.sv
// Shared encodings for the 5-stage RISC-V pipeline: result selects, forwarding
// mux selects and the hazard controller's memory-wait FSM states.
package riscv_pkg;

   localparam logic [1:0] RESULT_LOAD = 2'b01;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      ERR  = 2'b10
   } hz_state_t;

   // M has priority over W; x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic       reg_write_m,
                                          input logic [4:0] rd_m,
                                          input logic       reg_write_w,
                                          input logic [4:0] rd_w,
                                          input logic [4:0] rs);
      logic [1:0] sel;
      sel = FWD_RF;
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))
         sel = FWD_M;
      else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs))
         sel = FWD_W;
      return sel;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (inc && (q != '1))
         q <= q + W'(1);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush, and a
// freeze FSM for multi-cycle data memory accesses with timeout.
module hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [1:0]       ResultSrcE,
   input  logic             PCSrcE,
   input  logic [4:0]       RdM,
   input  logic             RegWriteM,
   input  logic             MemWriteM,
   input  logic [1:0]       ResultSrcM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteW,
   input  logic             dmem_ready,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hz_state_t  state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       mem_err_nxt;
   logic       freeze;
   logic       lw_stall;
   logic       mem_op_m;

   assign ForwardAE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
   assign ForwardBE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);

   assign lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
   assign mem_op_m = MemWriteM || (ResultSrcM == RESULT_LOAD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         mem_err  <= mem_err_nxt;
      end
   end

   // The IDLE cycle that launches a stalled access already counts as wait 1.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      mem_err_nxt  = mem_err;
      freeze       = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op_m && !dmem_ready) begin
               freeze       = 1'b1;
               state_nxt    = WAIT;
               wait_cnt_nxt = 8'd1;
            end
         end
         WAIT: begin
            if (dmem_ready) begin
               state_nxt    = IDLE;
               wait_cnt_nxt = '0;
            end else begin
               freeze = 1'b1;
               if (wait_cnt == 8'(MEM_TIMEOUT)) begin
                  state_nxt   = ERR;
                  mem_err_nxt = 1'b1;
               end else begin
                  wait_cnt_nxt = wait_cnt + 8'd1;
               end
            end
         end
         ERR: begin
            freeze      = 1'b1;
            mem_err_nxt = 1'b1;
         end
         default: begin
            state_nxt    = IDLE;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   // A freeze holds D and E, so branch/load-use decisions simply reappear later.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (freeze) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         StallF = lw_stall;
         StallD = lw_stall;
         FlushD = PCSrcE;
         FlushE = lw_stall || PCSrcE;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (freeze || lw_stall),
      .q   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (FlushE),
      .q   (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expectations queued per step, checked by
// immediate assertions against combinational outputs and post-edge state.
module tb_hazard_ctrl;
   import riscv_pkg::*;

   logic        clk, rst;
   logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic [1:0]  ResultSrcE, ResultSrcM;
   logic        PCSrcE, RegWriteM, MemWriteM, RegWriteW, dmem_ready;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        mem_err;
   logic [15:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .Rs1E       (Rs1E),
      .Rs2E       (Rs2E),
      .RdE        (RdE),
      .ResultSrcE (ResultSrcE),
      .PCSrcE     (PCSrcE),
      .RdM        (RdM),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .RdW        (RdW),
      .RegWriteW  (RegWriteW),
      .dmem_ready (dmem_ready),
      .StallF     (StallF),
      .StallD     (StallD),
      .StallE     (StallE),
      .StallM     (StallM),
      .FlushD     (FlushD),
      .FlushE     (FlushE),
      .FlushW     (FlushW),
      .ForwardAE  (ForwardAE),
      .ForwardBE  (ForwardBE),
      .mem_err    (mem_err),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  stl;  // {StallF, StallD, StallE, StallM}
      logic [2:0]  fl;   // {FlushD, FlushE, FlushW}
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        err;
      int unsigned sc;
      int unsigned fc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic clr();
      Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
      ResultSrcE = '0; ResultSrcM = '0;
      PCSrcE = 1'b0; RegWriteM = 1'b0; MemWriteM = 1'b0; RegWriteW = 1'b0;
      dmem_ready = 1'b1;
   endtask

   // Called just after a falling edge with inputs already applied.
   task automatic step(input string tag, input logic [3:0] stl, input logic [2:0] fl,
                       input logic [1:0] fa, input logic [1:0] fb, input logic err,
                       input int unsigned sc, input int unsigned fc);
      exp_t e, g;
      e.stl = stl; e.fl = fl; e.fa = fa; e.fb = fb; e.err = err; e.sc = sc; e.fc = fc;
      sb.push_back(e);
      #1;
      g = sb.pop_front();
      chk({tag, ".stall"},  {28'd0, StallF, StallD, StallE, StallM}, {28'd0, g.stl});
      chk({tag, ".flush"},  {29'd0, FlushD, FlushE, FlushW}, {29'd0, g.fl});
      chk({tag, ".fwdA"},   {30'd0, ForwardAE}, {30'd0, g.fa});
      chk({tag, ".fwdB"},   {30'd0, ForwardBE}, {30'd0, g.fb});
      @(posedge clk);
      #1;
      chk({tag, ".mem_err"},   {31'd0, mem_err}, {31'd0, g.err});
      chk({tag, ".stall_cnt"}, {16'd0, stall_cnt}, g.sc);
      chk({tag, ".flush_cnt"}, {16'd0, flush_cnt}, g.fc);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      clr();
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset.stall",     {28'd0, StallF, StallD, StallE, StallM}, 32'd0);
      chk("reset.flush",     {29'd0, FlushD, FlushE, FlushW}, 32'd0);
      chk("reset.mem_err",   {31'd0, mem_err}, 32'd0);
      chk("reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("reset.flush_cnt", {16'd0, flush_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Forwarding priority
      clr(); RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 5;
      step("fwd_m", 4'b0000, 3'b000, FWD_M, FWD_M, 0, 0, 0);
      RegWriteM = 0;
      step("fwd_w", 4'b0000, 3'b000, FWD_W, FWD_W, 0, 0, 0);
      RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
      step("fwd_x0", 4'b0000, 3'b000, FWD_RF, FWD_RF, 0, 0, 0);
      clr(); RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 9; Rs2E = 9;
      step("fwd_mix", 4'b0000, 3'b000, FWD_M, FWD_W, 0, 0, 0);

      // Load-use stall
      clr(); ResultSrcE = RESULT_LOAD; RdE = 7; Rs2D = 7;
      step("lw_stall", 4'b1100, 3'b010, FWD_RF, FWD_RF, 0, 1, 1);
      clr();
      step("lw_done", 4'b0000, 3'b000, FWD_RF, FWD_RF, 0, 1, 1);
      clr(); ResultSrcE = RESULT_LOAD; RdE = 0; Rs1D = 0;
      step("lw_x0", 4'b0000, 3'b000, FWD_RF, FWD_RF, 0, 1, 1);

      // Taken branch, alone and with a simultaneous load-use
      clr(); PCSrcE = 1;
      step("branch", 4'b0000, 3'b110, FWD_RF, FWD_RF, 0, 1, 2);
      clr(); PCSrcE = 1; ResultSrcE = RESULT_LOAD; RdE = 7; Rs1D = 7;
      step("br_lw", 4'b1100, 3'b110, FWD_RF, FWD_RF, 0, 2, 3);

      // Store waiting three cycles on memory
      clr(); MemWriteM = 1; dmem_ready = 0;
      step("sw_wait1", 4'b1111, 3'b001, FWD_RF, FWD_RF, 0, 3, 3);
      step("sw_wait2", 4'b1111, 3'b001, FWD_RF, FWD_RF, 0, 4, 3);
      step("sw_wait3", 4'b1111, 3'b001, FWD_RF, FWD_RF, 0, 5, 3);
      dmem_ready = 1;
      step("sw_rel", 4'b0000, 3'b000, FWD_RF, FWD_RF, 0, 5, 3);

      // Branch deferred while frozen
      clr(); MemWriteM = 1; dmem_ready = 0; PCSrcE = 1;
      step("brw_wait1", 4'b1111, 3'b001, FWD_RF, FWD_RF, 0, 6, 3);
      step("brw_wait2", 4'b1111, 3'b001, FWD_RF, FWD_RF, 0, 7, 3);
      step("brw_wait3", 4'b1111, 3'b001, FWD_RF, FWD_RF, 0, 8, 3);
      dmem_ready = 1;
      step("brw_rel", 4'b0000, 3'b110, FWD_RF, FWD_RF, 0, 8, 4);

      // Load timeout with MEM_TIMEOUT=4
      clr(); ResultSrcM = RESULT_LOAD; dmem_ready = 0;
      step("to_w1", 4'b1111, 3'b001, FWD_RF, FWD_RF, 0, 9, 4);
      step("to_w2", 4'b1111, 3'b001, FWD_RF, FWD_RF, 0, 10, 4);
      step("to_w3", 4'b1111, 3'b001, FWD_RF, FWD_RF, 0, 11, 4);
      step("to_w4", 4'b1111, 3'b001, FWD_RF, FWD_RF, 0, 12, 4);
      step("to_err", 4'b1111, 3'b001, FWD_RF, FWD_RF, 1, 13, 4);
      dmem_ready = 1; ResultSrcE = RESULT_LOAD; RdE = 3; Rs1D = 3; PCSrcE = 1;
      step("err_hold", 4'b1111, 3'b001, FWD_RF, FWD_RF, 1, 14, 4);

      // Asynchronous reset out of ERR
      clr();
      rst = 1'b1;
      #1;
      chk("rst_err.mem_err",   {31'd0, mem_err}, 32'd0);
      chk("rst_err.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("rst_err.flush_cnt", {16'd0, flush_cnt}, 32'd0);
      chk("rst_err.stall",     {28'd0, StallF, StallD, StallE, StallM}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      MemWriteM = 1;
      step("post_rdy", 4'b0000, 3'b000, FWD_RF, FWD_RF, 0, 0, 0);
      dmem_ready = 0;
      step("post_wait", 4'b1111, 3'b001, FWD_RF, FWD_RF, 0, 1, 0);
      dmem_ready = 1;
      step("post_rel", 4'b0000, 3'b000, FWD_RF, FWD_RF, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
